// File: rtl/coin_accumulator.sv
// Coin accumulator: sums accepted coins, then locks, refunds or clears the total.
// Optional feature COIN_TIMEOUT_EN: auto-refund after TIMEOUT_CYCLES idle cycles in COLLECT.
module coin_accumulator #(
  parameter int unsigned MAX_MONEY      = 200,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coinValid,
  input  logic [2:0] coinType,
  input  logic       cancel,
  input  logic       lock,
  input  logic       done,
  output logic [7:0] money,
  output logic       moneyValid,
  output logic       coinReject,
  output logic [7:0] refundAmount,
  output logic       refundValid
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    LOCKED,
    REFUND
  } state_e;

  state_e     state_q;
  logic [7:0] money_q;
  logic       moneyValid_q;
  logic       coinReject_q;
  logic [7:0] refundAmount_q;
  logic       refundValid_q;

  logic [7:0] coin_val;
  logic       type_ok;
  logic [8:0] sum;
  logic       coin_ok;

  always_comb begin
    coin_val = 8'd0;
    type_ok  = 1'b1;
    unique case (1'b1)
      (coinType == 3'd0): coin_val = 8'd1;
      (coinType == 3'd1): coin_val = 8'd5;
      (coinType == 3'd2): coin_val = 8'd10;
      (coinType == 3'd3): coin_val = 8'd20;
      (coinType == 3'd4): coin_val = 8'd50;
      default:            type_ok  = 1'b0;
    endcase
  end

  // Nine-bit sum so an overflowing coin can never wrap into range.
  assign sum     = {1'b0, money_q} + {1'b0, coin_val};
  assign coin_ok = coinValid && type_ok && (sum <= 9'(MAX_MONEY));

`ifdef COIN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      money_q        <= 8'd0;
      moneyValid_q   <= 1'b0;
      coinReject_q   <= 1'b0;
      refundAmount_q <= 8'd0;
      refundValid_q  <= 1'b0;
`ifdef COIN_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      coinReject_q   <= 1'b0;
      refundValid_q  <= 1'b0;
      refundAmount_q <= 8'd0;
`ifdef COIN_TIMEOUT_EN
      tmo_q          <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (coin_ok) begin
            money_q <= sum[7:0];
            state_q <= COLLECT;
          end else begin
            coinReject_q <= coinValid;
          end
        end
        COLLECT: begin
          if (cancel) begin
            coinReject_q   <= coinValid;
            state_q        <= REFUND;
            refundValid_q  <= 1'b1;
            refundAmount_q <= money_q;
          end else if (lock) begin
            coinReject_q <= coinValid;
            state_q      <= LOCKED;
            moneyValid_q <= 1'b1;
          end else if (coin_ok) begin
            money_q <= sum[7:0];
          end else begin
            coinReject_q <= coinValid;
`ifdef COIN_TIMEOUT_EN
            if (tmo_hit) begin
              state_q        <= REFUND;
              refundValid_q  <= 1'b1;
              refundAmount_q <= money_q;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
`endif
          end
        end
        LOCKED: begin
          coinReject_q <= coinValid;
          if (done) begin
            state_q      <= IDLE;
            money_q      <= 8'd0;
            moneyValid_q <= 1'b0;
          end else if (cancel) begin
            state_q        <= REFUND;
            moneyValid_q   <= 1'b0;
            refundValid_q  <= 1'b1;
            refundAmount_q <= money_q;
          end
        end
        REFUND: begin
          coinReject_q <= coinValid;
          state_q      <= IDLE;
          money_q      <= 8'd0;
        end
      endcase
    end
  end

  assign money        = money_q;
  assign moneyValid   = moneyValid_q;
  assign coinReject   = coinReject_q;
  assign refundAmount = refundAmount_q;
  assign refundValid  = refundValid_q;

endmodule
